// File: rtl/packet_transmitter_if.sv
// Outbound 16-bit word stream with valid/ready handshake and end-of-packet marker.
// The master drives data and valid; the slave answers with ready.
interface packet_transmitter_if;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;

  modport master (output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/packet_transmitter.sv
// Builds and serialises the routing-feedback packet: header, sink count, sink IDs and
// a trailing XOR checksum, reading the known-sink table from node memory.
module packet_transmitter #(
  parameter int          MAX_SINKS = 16,
  parameter logic [10:0] CNT_ADDR  = 11'h688,
  parameter logic [10:0] SINK_BASE = 11'h008
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 node_id,
  input  logic [15:0]                 cluster_id,
  input  logic [15:0]                 battery_stat,
  input  logic [15:0]                 best_value,
  input  logic [15:0]                 action,
  output logic [10:0]                 mem_addr,
  input  logic [15:0]                 mem_data_out,
  packet_transmitter_if.master        tx,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RD_ADDR, S_RD_WAIT, S_EMIT, S_CSUM, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  hdr_idx_q;
  logic [15:0] sink_idx_q;
  logic [15:0] n_sinks_q;
  logic        is_count_q;
  logic [15:0] csum_q;
  logic [10:0] mem_addr_q;
  logic        addr_ld;
  logic [10:0] addr_d;

  logic [15:0] node_q, batt_q, value_q, cluster_q, action_q;
  logic [15:0] word_q;

  function automatic logic [15:0] clamp_count(input logic [15:0] raw);
    if (raw > 16'(MAX_SINKS)) return 16'(MAX_SINKS);
    return raw;
  endfunction

  function automatic logic [10:0] sink_addr(input logic [15:0] idx);
    return SINK_BASE + {idx[9:0], 1'b0};
  endfunction

  assign mem_addr = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    addr_ld     = 1'b0;
    addr_d      = mem_addr_q;
    tx.tx_valid = 1'b0;
    tx.tx_last  = 1'b0;
    tx.tx_data  = '0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        unique case (hdr_idx_q)
          3'd0:    tx.tx_data = node_q;
          3'd1:    tx.tx_data = batt_q;
          3'd2:    tx.tx_data = value_q;
          3'd3:    tx.tx_data = cluster_q;
          default: tx.tx_data = action_q;
        endcase
        if (tx.tx_ready && hdr_idx_q == 3'd4) begin
          state_d = S_RD_ADDR;
          addr_ld = 1'b1;
          addr_d  = CNT_ADDR;
        end
      end
      S_RD_ADDR: begin
        busy    = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy    = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = word_q;
        if (tx.tx_ready) begin
          if (is_count_q) begin
            if (n_sinks_q == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_RD_ADDR;
              addr_ld = 1'b1;
              addr_d  = sink_addr(16'd0);
            end
          end else if (sink_idx_q + 16'd1 < n_sinks_q) begin
            state_d = S_RD_ADDR;
            addr_ld = 1'b1;
            addr_d  = sink_addr(sink_idx_q + 16'd1);
          end else begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_last  = 1'b1;
        tx.tx_data  = csum_q;
        if (tx.tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: state, indices, checksum and address
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= '0;
      sink_idx_q <= '0;
      n_sinks_q  <= '0;
      is_count_q <= 1'b0;
      csum_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (addr_ld) mem_addr_q <= addr_d;
      if (state_q == S_IDLE && start) begin
        hdr_idx_q  <= '0;
        sink_idx_q <= '0;
        is_count_q <= 1'b1;
        csum_q     <= '0;
      end
      // checksum covers every accepted word except itself
      if (tx.tx_valid && tx.tx_ready && state_q != S_CSUM)
        csum_q <= csum_q ^ tx.tx_data;
      if (state_q == S_HDR && tx.tx_ready) hdr_idx_q <= hdr_idx_q + 3'd1;
      if (state_q == S_RD_WAIT && is_count_q) n_sinks_q <= clamp_count(mem_data_out);
      if (state_q == S_EMIT && tx.tx_ready) begin
        if (is_count_q) begin
          is_count_q <= 1'b0;
          sink_idx_q <= '0;
        end else begin
          sink_idx_q <= sink_idx_q + 16'd1;
        end
      end
    end
  end

  // Data registers: latched header and the word fetched from memory
  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && start) begin
      node_q    <= node_id;
      batt_q    <= battery_stat;
      value_q   <= best_value;
      cluster_q <= cluster_id;
      action_q  <= action;
    end
    if (state_q == S_RD_WAIT)
      word_q <= is_count_q ? clamp_count(mem_data_out) : mem_data_out;
  end

endmodule

// File: tb/tb_packet_transmitter.sv
// Bench for packet_transmitter: directed vector table, abort/restart sequence and
// randomized packets against a queue-based packet model with a synchronous memory model.
module tb_packet_transmitter;
  logic        clock = 1'b0;
  logic        rst, start;
  logic [15:0] node_id, cluster_id, battery_stat, best_value, action;
  logic [10:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        busy, done;

  packet_transmitter_if tx_if();

  packet_transmitter dut (
    .clock        (clock),
    .rst          (rst),
    .start        (start),
    .node_id      (node_id),
    .cluster_id   (cluster_id),
    .battery_stat (battery_stat),
    .best_value   (best_value),
    .action       (action),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .tx           (tx_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:2047];
  always @(posedge clock) mem_data_out <= mem[mem_addr];

  typedef struct {
    logic [15:0] node, batt, val, clus, act;
  } hdr_t;

  typedef struct {
    logic [15:0] node, batt, val, clus, act;
    logic [15:0] cnt;
    logic [15:0] sink0;
    int          ready_mode;
    int          mid_start;
    int          exp_words;
    logic [15:0] exp_csum;
    logic [10:0] exp_last_addr;
    int          exp_cycles;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] got_w[$];
  bit          got_l[$];
  logic [10:0] got_a[$];
  logic [15:0] exp_w[$];
  logic [10:0] exp_a[$];
  int          done_cnt, done_cyc;
  bit          aborted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [15:0] cnt, input logic [15:0] sink0, input bit rnd);
    mem[11'h688] = cnt;
    for (int i = 0; i < 20; i++) begin
      mem[11'h008 + 11'(2*i)] = rnd ? 16'($urandom) : sink0 + 16'(i);
      mem[11'h009 + 11'(2*i)] = 16'hBAD0 + 16'(i);
    end
  endtask

  // Packet as the rules describe it: header, clamped count, sinks, XOR of all of them
  task automatic model(input hdr_t h);
    int n;
    logic [15:0] cs;
    exp_w.delete();
    exp_a.delete();
    exp_w.push_back(h.node);
    exp_w.push_back(h.batt);
    exp_w.push_back(h.val);
    exp_w.push_back(h.clus);
    exp_w.push_back(h.act);
    n = (mem[11'h688] > 16'd16) ? 16 : int'(mem[11'h688]);
    exp_a.push_back(11'h688);
    exp_w.push_back(16'(n));
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(11'h008 + 11'(2*i));
      exp_w.push_back(mem[11'h008 + 11'(2*i)]);
    end
    cs = '0;
    foreach (exp_w[k]) cs ^= exp_w[k];
    exp_w.push_back(cs);
  endtask

  // ready_mode: 0 always ready, 1 three-cycle stalls on W2 and checksum, 2 random
  task automatic run_packet(input hdr_t h, input int ready_mode, input int mid_start_cyc,
                            input int rst_at_read);
    logic [15:0] pd;
    bit pv, pr, pl, pb, r;
    int stall, rst_stage;
    got_w.delete(); got_l.delete(); got_a.delete();
    done_cnt = 0; done_cyc = 0; aborted = 0;
    pv = 0; pr = 0; pl = 0; pb = 0; pd = '0; stall = 0; rst_stage = 0;
    @(negedge clock);
    node_id = h.node; battery_stat = h.batt; best_value = h.val;
    cluster_id = h.clus; action = h.act;
    start = 1'b1;
    tx_if.tx_ready = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clock);
      start = (cyc == mid_start_cyc);
      node_id = 16'($urandom); battery_stat = 16'($urandom); best_value = 16'($urandom);
      cluster_id = 16'($urandom); action = 16'($urandom);
      if (rst_stage == 2) begin
        rst = 1'b0;
        check("abort tx_valid", tx_if.tx_valid, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort mem_addr", mem_addr, 0);
        aborted = 1;
        break;
      end
      if (rst_stage == 1) begin
        rst = 1'b1;
        rst_stage = 2;
      end
      if (pv && !pr) begin
        check("hold valid", tx_if.tx_valid, 1);
        check("hold data", tx_if.tx_data, pd);
        check("hold last", tx_if.tx_last, pl);
      end
      if (busy && !tx_if.tx_valid && pb && pv) begin
        got_a.push_back(mem_addr);
        if (rst_at_read != 0 && got_a.size() == rst_at_read) rst_stage = 1;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          check("busy low at done", busy, 0);
        end
      end
      case (ready_mode)
        1: begin
          if (tx_if.tx_valid && (got_w.size() == 2 || tx_if.tx_last) && stall < 3) begin
            r = 1'b0;
            stall++;
          end else r = 1'b1;
        end
        2: r = ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      tx_if.tx_ready = r;
      if (tx_if.tx_valid && r) begin
        got_w.push_back(tx_if.tx_data);
        got_l.push_back(tx_if.tx_last);
        stall = 0;
      end
      pv = tx_if.tx_valid; pr = r; pd = tx_if.tx_data; pl = tx_if.tx_last; pb = busy;
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
    end
    if (!aborted && done_cnt == 0) check("done within cycle budget", 0, 1);
  endtask

  task automatic compare_packet(input string tag);
    int m;
    check($sformatf("%s word count", tag), got_w.size(), exp_w.size());
    m = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s word %0d", tag, k), got_w[k], exp_w[k]);
      check($sformatf("%s last %0d", tag, k), got_l[k], (k == exp_w.size() - 1));
    end
    check($sformatf("%s read count", tag), got_a.size(), exp_a.size());
    m = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int k = 0; k < m; k++)
      check($sformatf("%s addr %0d", tag, k), got_a[k], exp_a[k]);
    check($sformatf("%s done pulses", tag), done_cnt, 1);
  endtask

  vec_t vecs[5];
  hdr_t h;

  initial begin
    vecs[0] = '{16'h0003, 16'h5999, 16'h0100, 16'h0001, 16'h0005, 16'd0,  16'h0000, 0, 0,  7,  16'h589E, 11'h688, 10};
    vecs[1] = '{16'h0003, 16'h5999, 16'h0100, 16'h0001, 16'h0005, 16'd2,  16'h000A, 0, 0,  9,  16'h589D, 11'h00A, 16};
    vecs[2] = '{16'h0003, 16'h5999, 16'h0100, 16'h0001, 16'h0005, 16'd2,  16'h000A, 1, 0,  9,  16'h589D, 11'h00A, 0};
    vecs[3] = '{16'h0003, 16'h5999, 16'h0100, 16'h0001, 16'h0005, 16'd20, 16'h0100, 0, 0,  23, 16'h588E, 11'h026, 58};
    vecs[4] = '{16'h0003, 16'h5999, 16'h0100, 16'h0001, 16'h0005, 16'd2,  16'h000A, 0, 10, 9,  16'h589D, 11'h00A, 16};

    for (int i = 0; i < 2048; i++) mem[i] = 16'(i) ^ 16'h3C3C;
    rst = 1'b1; start = 1'b0; tx_if.tx_ready = 1'b0;
    node_id = '0; cluster_id = '0; battery_stat = '0; best_value = '0; action = '0;
    repeat (3) @(negedge clock);
    check("reset tx_valid", tx_if.tx_valid, 0);
    check("reset tx_last", tx_if.tx_last, 0);
    check("reset tx_data", tx_if.tx_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mem_addr", mem_addr, 0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      h = '{vecs[v].node, vecs[v].batt, vecs[v].val, vecs[v].clus, vecs[v].act};
      load_mem(vecs[v].cnt, vecs[v].sink0, 1'b0);
      run_packet(h, vecs[v].ready_mode, vecs[v].mid_start, 0);
      model(h);
      compare_packet($sformatf("vec%0d", v));
      check($sformatf("vec%0d words", v), got_w.size(), vecs[v].exp_words);
      if (got_w.size() > 0) check($sformatf("vec%0d checksum", v), got_w[$], vecs[v].exp_csum);
      if (got_a.size() > 0) check($sformatf("vec%0d last addr", v), got_a[$], vecs[v].exp_last_addr);
      if (vecs[v].exp_cycles != 0) check($sformatf("vec%0d start-to-done", v), done_cyc, vecs[v].exp_cycles);
    end

    // Abort during the read of sink 1, then a clean packet with a new header
    h = '{16'h0003, 16'h5999, 16'h0100, 16'h0001, 16'h0005};
    load_mem(16'd2, 16'h000A, 1'b0);
    run_packet(h, 0, 0, 3);
    check("abort taken", aborted, 1);
    h = '{16'h0007, 16'h1234, 16'h0042, 16'h0002, 16'h0009};
    run_packet(h, 0, 0, 0);
    model(h);
    compare_packet("after abort");
    if (got_w.size() > 0) check("after abort checksum", got_w[$], 16'h1279);

    for (int t = 0; t < 8; t++) begin
      h = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      load_mem(16'($urandom_range(0, 20)), 16'h0000, 1'b1);
      run_packet(h, 2, 0, 0);
      model(h);
      compare_packet($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
